// File: rtl/pwm_meter_pkg.sv
`default_nettype none
// ============================================================================
// pwm_meter_pkg : shared types and constants for the PWM period/duty meter
// Rev 1.0
// ============================================================================
package pwm_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEASURE   = 2'd1,
        STALLED   = 2'd2
    } state_e;

    localparam int CNT_WIDTH_DEF  = 16;
    localparam int DUTY_WIDTH_DEF = 8;
    localparam int CNT_MAX        = (1 << CNT_WIDTH_DEF) - 1;
    localparam int DIV_LAT        = DUTY_WIDTH_DEF + 1;

    function automatic int sync_depth(input int stages);
        return (stages < 2) ? 2 : stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_div.sv
`default_nettype none
// ============================================================================
// pwm_duty_div : serial restoring divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
module pwm_duty_div #(
    parameter int CNT_WIDTH  = 16,
    parameter int DUTY_WIDTH = 8
) (
    input  logic                            emu_clk,
    input  logic                            emu_rst,
    input  logic                            start_i,
    input  logic [CNT_WIDTH+DUTY_WIDTH-1:0] dividend_i,
    input  logic [CNT_WIDTH-1:0]            divisor_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [DUTY_WIDTH-1:0]           quotient_o
);

    localparam int c_dvd_w = CNT_WIDTH + DUTY_WIDTH;
    localparam int c_cnt_w = $clog2(DUTY_WIDTH + 1);

    logic [CNT_WIDTH-1:0]  rem_q;
    logic [CNT_WIDTH-1:0]  div_q;
    logic [DUTY_WIDTH-1:0] bits_q;
    logic [DUTY_WIDTH-1:0] quo_q;
    logic [c_cnt_w-1:0]    cnt_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  w_start;
    logic [CNT_WIDTH-1:0]  w_rem_in;
    logic                  w_bit_in;
    logic [CNT_WIDTH-1:0]  w_dsr;
    logic [CNT_WIDTH:0]    w_trial;
    logic [CNT_WIDTH-1:0]  w_diff;
    logic                  w_qbit;
    logic [CNT_WIDTH-1:0]  w_rem_out;

    assign w_start = start_i & ~busy_q;

    // The first step runs in the load cycle. Because high < period, the top
    // CNT_WIDTH-1 dividend bits are already a valid partial remainder.
    always_comb begin
        w_rem_in  = w_start ? {1'b0, dividend_i[c_dvd_w-1:DUTY_WIDTH+1]} : rem_q;
        w_bit_in  = w_start ? dividend_i[DUTY_WIDTH] : bits_q[DUTY_WIDTH-1];
        w_dsr     = w_start ? divisor_i : div_q;
        w_trial   = {w_rem_in, w_bit_in};
        w_qbit    = (w_trial >= {1'b0, w_dsr});
        w_diff    = w_trial[CNT_WIDTH-1:0] - w_dsr;
        w_rem_out = w_qbit ? w_diff : w_trial[CNT_WIDTH-1:0];
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            bits_q <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_start) begin
                rem_q  <= w_rem_out;
                div_q  <= divisor_i;
                bits_q <= dividend_i[DUTY_WIDTH-1:0];
                quo_q  <= {{(DUTY_WIDTH-1){1'b0}}, w_qbit};
                cnt_q  <= c_cnt_w'(DUTY_WIDTH);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    rem_q  <= w_rem_out;
                    bits_q <= {bits_q[DUTY_WIDTH-2:0], 1'b0};
                    quo_q  <= {quo_q[DUTY_WIDTH-2:0], w_qbit};
                    cnt_q  <= cnt_q - c_cnt_w'(1);
                    if (cnt_q == c_cnt_w'(1)) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule
`default_nettype wire

// File: rtl/pwm_meter.sv
`default_nettype none
// ============================================================================
// pwm_meter : measures PWM period, high time and fixed-point duty cycle
// Rev 1.0
// ============================================================================
module pwm_meter
    import pwm_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DUTY_WIDTH  = DUTY_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  pwm_in,
    input  logic                  clr_flags,
    output logic [CNT_WIDTH-1:0]  period_out,
    output logic [CNT_WIDTH-1:0]  high_out,
    output logic [DUTY_WIDTH-1:0] duty_out,
    output logic                  meas_valid,
    output logic                  stalled,
    output logic                  overrun
);

    localparam int                   c_sync    = sync_depth(SYNC_STAGES);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [c_sync-1:0]     sync_q;
    logic                  s_prev_q;
    logic                  w_s;
    logic                  w_rise;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_WIDTH-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]  cap_period_q, cap_period_d;
    logic [CNT_WIDTH-1:0]  cap_high_q, cap_high_d;
    logic [CNT_WIDTH-1:0]  period_out_q, period_out_d;
    logic [CNT_WIDTH-1:0]  high_out_q, high_out_d;
    logic [DUTY_WIDTH-1:0] duty_out_q, duty_out_d;
    logic                  meas_valid_q, meas_valid_d;
    logic                  stalled_q, stalled_d;
    logic                  overrun_q, overrun_d;

    logic                  w_div_start;
    logic                  w_div_busy;
    logic                  w_div_done;
    logic [DUTY_WIDTH-1:0] w_div_quo;
    logic                  w_ovr_set;

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[c_sync-2:0], pwm_in};
            s_prev_q <= w_s;
        end
    end

    assign w_s    = sync_q[c_sync-1];
    assign w_rise = w_s & ~s_prev_q;

    pwm_duty_div #(
        .CNT_WIDTH  (CNT_WIDTH),
        .DUTY_WIDTH (DUTY_WIDTH)
    ) u_div (
        .emu_clk    (emu_clk),
        .emu_rst    (emu_rst),
        .start_i    (w_div_start),
        .dividend_i ({high_cnt_q, {DUTY_WIDTH{1'b0}}}),
        .divisor_i  (period_cnt_q),
        .busy_o     (w_div_busy),
        .done_o     (w_div_done),
        .quotient_o (w_div_quo)
    );

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q <= WAIT_RISE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        cap_period_d = cap_period_q;
        cap_high_d   = cap_high_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        duty_out_d   = duty_out_q;
        meas_valid_d = 1'b0;
        stalled_d    = stalled_q;
        w_div_start  = 1'b0;
        w_ovr_set    = 1'b0;

        unique case (state_q)
            WAIT_RISE: begin
                if (w_rise) begin
                    period_cnt_d = c_cnt_one;
                    high_cnt_d   = c_cnt_one;
                    state_d      = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    period_cnt_d = c_cnt_one;
                    high_cnt_d   = c_cnt_one;
                    if (w_div_busy) begin
                        w_ovr_set = 1'b1;
                    end else begin
                        w_div_start  = 1'b1;
                        cap_period_d = period_cnt_q;
                        cap_high_d   = high_cnt_q;
                    end
                end else if (period_cnt_q == c_cnt_max) begin
                    // A line stuck high reads as 100 % duty, stuck low as 0 %.
                    state_d      = STALLED;
                    stalled_d    = 1'b1;
                    period_out_d = c_cnt_max;
                    high_out_d   = w_s ? period_cnt_q : '0;
                    duty_out_d   = {DUTY_WIDTH{w_s}};
                    meas_valid_d = 1'b1;
                end else begin
                    period_cnt_d = period_cnt_q + c_cnt_one;
                    if (w_s && (high_cnt_q != c_cnt_max)) begin
                        high_cnt_d = high_cnt_q + c_cnt_one;
                    end
                end
            end
            STALLED: begin
                if (w_rise) begin
                    stalled_d    = 1'b0;
                    period_cnt_d = c_cnt_one;
                    high_cnt_d   = c_cnt_one;
                    state_d      = MEASURE;
                end
            end
            default: begin
                state_d = WAIT_RISE;
            end
        endcase

        if (w_div_done) begin
            period_out_d = cap_period_q;
            high_out_d   = cap_high_q;
            duty_out_d   = w_div_quo;
            meas_valid_d = 1'b1;
        end

        overrun_d = w_ovr_set | (overrun_q & ~clr_flags);
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            cap_period_q <= '0;
            cap_high_q   <= '0;
            period_out_q <= '0;
            high_out_q   <= '0;
            duty_out_q   <= '0;
            meas_valid_q <= 1'b0;
            stalled_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            cap_period_q <= cap_period_d;
            cap_high_q   <= cap_high_d;
            period_out_q <= period_out_d;
            high_out_q   <= high_out_d;
            duty_out_q   <= duty_out_d;
            meas_valid_q <= meas_valid_d;
            stalled_q    <= stalled_d;
            overrun_q    <= overrun_d;
        end
    end

    assign period_out = period_out_q;
    assign high_out   = high_out_q;
    assign duty_out   = duty_out_q;
    assign meas_valid = meas_valid_q;
    assign stalled    = stalled_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire
